// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC tile: forwards operands east/south one cycle late and
// accumulates operand products through a two-stage pipeline.
module systolic_mac_pe #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    input  logic              inValid,
    input  logic              clearAcc,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              outValid,
    output logic [ACC_W-1:0]  accOut,
    output logic              accValid,
    output logic              overflow
);
    localparam int PROD_W    = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit IS_SAT    = (SATURATE != 0);

    generate
        if (ACC_W < PROD_W) begin : g_acc_too_narrow
            $error("systolic_mac_pe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_out_a;
    logic [DATA_W-1:0] r_out_b;
    logic              r_out_valid;
    logic [PROD_W-1:0] r_prod;
    logic              r_v1;
    logic              r_c1;
    logic [ACC_W-1:0]  r_acc;
    logic              r_acc_valid;
    logic              r_overflow;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_p_ext;
    logic [ACC_W:0]    w_sum_full;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_sat_val;
    logic [ACC_W-1:0]  w_acc_add;
    logic              w_carry;
    logic              w_signed_ovf;
    logic              w_ovf;

    // Widening both operands to the product width first makes the low bits of
    // a plain multiply the correct product in either signedness.
    assign w_a_ext = {{DATA_W{IS_SIGNED & inA[DATA_W-1]}}, inA};
    assign w_b_ext = {{DATA_W{IS_SIGNED & inB[DATA_W-1]}}, inB};
    assign w_prod  = w_a_ext * w_b_ext;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign w_p_ext = {{(ACC_W-PROD_W){IS_SIGNED & r_prod[PROD_W-1]}}, r_prod};
        end else begin : g_noext
            assign w_p_ext = r_prod;
        end
    endgenerate

    assign w_sum_full   = {1'b0, r_acc} + {1'b0, w_p_ext};
    assign w_sum        = w_sum_full[ACC_W-1:0];
    assign w_carry      = w_sum_full[ACC_W];
    assign w_signed_ovf = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                          (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_ovf        = IS_SIGNED ? w_signed_ovf : w_carry;

    // On signed overflow both addends share a sign, so the accumulator's sign
    // picks the rail to clamp to.
    assign w_sat_val = !IS_SIGNED      ? {ACC_W{1'b1}} :
                       r_acc[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};
    assign w_acc_add = (IS_SAT && w_ovf) ? w_sat_val : w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_v1        <= 1'b0;
            r_c1        <= 1'b0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_a     <= inA;
            r_out_b     <= inB;
            r_out_valid <= inValid;
            r_prod      <= w_prod;
            r_v1        <= inValid;
            r_c1        <= clearAcc;
            r_acc_valid <= r_v1;
            if (r_v1 && r_c1) begin
                r_acc      <= w_p_ext;
                r_overflow <= 1'b0;
            end else if (r_v1) begin
                r_acc      <= w_acc_add;
                r_overflow <= r_overflow | w_ovf;
            end else if (r_c1) begin
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign outA     = r_out_a;
    assign outB     = r_out_b;
    assign outValid = r_out_valid;
    assign accOut   = r_acc;
    assign accValid = r_acc_valid;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Scoreboard bench: five PE configurations share one randomized stimulus stream
// and are checked against an integer-arithmetic accumulator model.
`timescale 1ns/1ps
module tb_systolic_mac_pe;
    localparam int N = 5;

    typedef struct {
        longint acc;
        bit     ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       inValid;
    logic       clearAcc;

    logic [7:0]  oa [N];
    logic [7:0]  ob [N];
    logic        ovld [N];
    logic        av [N];
    logic        ovf_o [N];
    logic [19:0] acc0;
    logic [15:0] acc1;
    logic [15:0] acc2;
    logic [15:0] acc3;
    logic [15:0] acc4;

    int n_cmp = 0;
    int n_bad = 0;

    // Configuration of each instance, in instance order.
    int cfg_w   [N] = '{20, 16, 16, 16, 16};
    bit cfg_s   [N] = '{0, 0, 0, 1, 1};
    bit cfg_sat [N] = '{1, 1, 0, 1, 0};

    longint m_acc [N];
    bit     m_ovf [N];
    exp_t   q [N][$];

    always #5 clk = ~clk;

    systolic_mac_pe #(.DATA_W(8), .ACC_W(20), .SIGNED(0), .SATURATE(1)) u0 (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .inValid(inValid), .clearAcc(clearAcc),
        .outA(oa[0]), .outB(ob[0]), .outValid(ovld[0]), .accOut(acc0), .accValid(av[0]), .overflow(ovf_o[0]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .inValid(inValid), .clearAcc(clearAcc),
        .outA(oa[1]), .outB(ob[1]), .outValid(ovld[1]), .accOut(acc1), .accValid(av[1]), .overflow(ovf_o[1]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .inValid(inValid), .clearAcc(clearAcc),
        .outA(oa[2]), .outB(ob[2]), .outValid(ovld[2]), .accOut(acc2), .accValid(av[2]), .overflow(ovf_o[2]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .inValid(inValid), .clearAcc(clearAcc),
        .outA(oa[3]), .outB(ob[3]), .outValid(ovld[3]), .accOut(acc3), .accValid(av[3]), .overflow(ovf_o[3]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u4 (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .inValid(inValid), .clearAcc(clearAcc),
        .outA(oa[4]), .outB(ob[4]), .outValid(ovld[4]), .accOut(acc4), .accValid(av[4]), .overflow(ovf_o[4]));

    function automatic longint acc_of(int d);
        case (d)
            0:       return longint'(acc0);
            1:       return longint'(acc1);
            2:       return longint'(acc2);
            3:       return longint'(acc3);
            default: return longint'(acc4);
        endcase
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_pe(int d, string nm, longint acc_e, bit av_e, bit ovf_e);
        chk($sformatf("%s_acc_d%0d", nm, d), acc_of(d), acc_e);
        chk($sformatf("%s_accValid_d%0d", nm, d), longint'(av[d]), longint'(av_e));
        chk($sformatf("%s_overflow_d%0d", nm, d), longint'(ovf_o[d]), longint'(ovf_e));
    endtask

    // Reference: the accumulator as a mathematical integer, range-checked
    // against the representable interval of each configuration.
    task automatic model_step(logic [7:0] a, logic [7:0] b, bit v, bit c, bit rst);
        longint p, sum, hi, lo, span;
        for (int d = 0; d < N; d++) begin
            span = longint'(1) << cfg_w[d];
            hi   = cfg_s[d] ? (span / 2) - 1 : span - 1;
            lo   = cfg_s[d] ? -(span / 2) : 0;
            p    = cfg_s[d] ? longint'($signed(a)) * longint'($signed(b))
                            : longint'(a) * longint'(b);
            if (rst) begin
                m_acc[d] = 0;
                m_ovf[d] = 1'b0;
                q[d].delete();
            end else if (v) begin
                if (c) begin
                    m_acc[d] = p;
                    m_ovf[d] = 1'b0;
                end else begin
                    sum = m_acc[d] + p;
                    if (sum > hi) begin
                        m_ovf[d] = 1'b1;
                        m_acc[d] = cfg_sat[d] ? hi : sum - span;
                    end else if (sum < lo) begin
                        m_ovf[d] = 1'b1;
                        m_acc[d] = cfg_sat[d] ? lo : sum + span;
                    end else begin
                        m_acc[d] = sum;
                    end
                end
                q[d].push_back('{m_acc[d] & (span - 1), m_ovf[d]});
            end else if (c) begin
                m_acc[d] = 0;
                m_ovf[d] = 1'b0;
            end
        end
    endtask

    task automatic cyc(logic [7:0] a, logic [7:0] b, bit v, bit c, bit rst);
        inA      = a;
        inB      = b;
        inValid  = v;
        clearAcc = c;
        reset    = rst;
        model_step(a, b, v, c, rst);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: forward path against the inputs of the previous edge, and every
    // accValid pulse against the next queued model result.
    initial begin
        logic [7:0] pa, pb;
        logic       pv, pr;
        exp_t       e;
        forever begin
            @(posedge clk);
            pa = inA;
            pb = inB;
            pv = inValid;
            pr = reset;
            #1;
            for (int d = 0; d < N; d++) begin
                chk($sformatf("fwd_outA_d%0d", d), longint'(oa[d]), pr ? 0 : longint'(pa));
                chk($sformatf("fwd_outB_d%0d", d), longint'(ob[d]), pr ? 0 : longint'(pb));
                chk($sformatf("fwd_outValid_d%0d", d), longint'(ovld[d]), pr ? 0 : longint'(pv));
                if (av[d] === 1'b1) begin
                    if (q[d].size() == 0) begin
                        chk($sformatf("unexpected_accValid_d%0d", d), 1, 0);
                    end else begin
                        e = q[d].pop_front();
                        chk($sformatf("sb_acc_d%0d", d), acc_of(d), e.acc);
                        chk($sformatf("sb_overflow_d%0d", d), longint'(ovf_o[d]), longint'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] a, b;
        int         mode;

        inA = 8'hAA; inB = 8'h55; inValid = 1'b1; clearAcc = 1'b1; reset = 1'b1;
        cyc(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
        cyc(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        for (int d = 0; d < N; d++) chk_pe(d, "reset", 0, 1'b0, 1'b0);

        // Unsigned accumulate
        cyc(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
        cyc(8'd4, 8'd5, 1'b1, 1'b0, 1'b0);
        chk_pe(0, "uacc1", 6, 1'b1, 1'b0);
        cyc(8'd10, 8'd10, 1'b1, 1'b0, 1'b0);
        chk_pe(0, "uacc2", 26, 1'b1, 1'b0);
        idle();
        chk_pe(0, "uacc3", 126, 1'b1, 1'b0);
        idle();
        chk_pe(0, "uacc_hold", 126, 1'b0, 1'b0);

        // Saturate vs wrap, 16-bit unsigned
        cyc(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
        cyc(8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
        chk_pe(1, "sat1", 65025, 1'b1, 1'b0);
        chk_pe(2, "wrap1", 65025, 1'b1, 1'b0);
        cyc(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        chk_pe(1, "sat2", 65535, 1'b1, 1'b1);
        chk_pe(2, "wrap2", 64514, 1'b1, 1'b1);
        idle();
        chk_pe(1, "sat_clr", 1, 1'b1, 1'b0);
        chk_pe(2, "wrap_clr", 1, 1'b1, 1'b0);

        // Signed, 16-bit
        cyc(8'hFD, 8'd4, 1'b1, 1'b1, 1'b0);
        cyc(8'd2, 8'd2, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s1", 'hFFF4, 1'b1, 1'b0);
        cyc(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s2", 'hFFF8, 1'b1, 1'b0);
        cyc(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s3", 16376, 1'b1, 1'b0);
        cyc(8'd7, 8'd1, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s4", 32760, 1'b1, 1'b0);
        cyc(8'd1, 8'd1, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s5", 32767, 1'b1, 1'b0);
        cyc(8'hFF, 8'd1, 1'b1, 1'b0, 1'b0);
        chk_pe(3, "s_sat", 32767, 1'b1, 1'b1);
        chk_pe(4, "s_wrap", 'h8000, 1'b1, 1'b1);
        idle();
        chk_pe(3, "s_unpin", 32766, 1'b1, 1'b1);
        chk_pe(4, "s_wrap2", 'h7FFF, 1'b1, 1'b1);

        // Bubbles
        cyc(8'd7, 8'd1, 1'b1, 1'b1, 1'b0);
        idle();
        chk_pe(0, "bub1", 7, 1'b1, 1'b0);
        idle();
        chk_pe(0, "bub2", 7, 1'b0, 1'b0);
        cyc(8'd9, 8'd1, 1'b1, 1'b0, 1'b0);
        chk_pe(0, "bub3", 7, 1'b0, 1'b0);
        idle();
        chk_pe(0, "bub4", 16, 1'b1, 1'b0);

        // Clear without data
        cyc(8'd20, 8'd25, 1'b1, 1'b1, 1'b0);
        idle();
        chk_pe(0, "clr_pre", 500, 1'b1, 1'b0);
        cyc(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk_pe(0, "clr_mid", 500, 1'b0, 1'b0);
        idle();
        chk_pe(0, "clr_done", 0, 1'b0, 1'b0);

        // Reset mid-operation
        cyc(8'd3, 8'd3, 1'b1, 1'b1, 1'b0);
        idle();
        chk_pe(0, "rst_pre", 9, 1'b1, 1'b0);
        cyc(8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int d = 0; d < N; d++) chk_pe(d, "rst_mid", 0, 1'b0, 1'b0);
        cyc(8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
        chk_pe(0, "rst_after", 0, 1'b0, 1'b0);
        idle();
        chk_pe(0, "rst_next", 2, 1'b1, 1'b0);

        // Randomized traffic in blocks biased toward overflow in either direction
        for (int blk = 0; blk < 20; blk++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 40; i++) begin
                case (mode)
                    0: begin a = 8'($urandom); b = 8'($urandom); end
                    1: begin a = 8'($urandom_range(128, 144)); b = 8'($urandom_range(128, 144)); end
                    default: begin a = 8'($urandom_range(112, 127)); b = 8'($urandom_range(128, 144)); end
                endcase
                cyc(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 149) == 0);
            end
        end

        idle();
        idle();
        idle();
        for (int d = 0; d < N; d++)
            chk($sformatf("drain_pending_d%0d", d), longint'(q[d].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
